coil_drive_stage: RTL

//  Downstream stage of the stepper phase-sequence FSM. It consumes the 4-bit coil pattern and drives
//  the H-bridge coil outputs. It inserts break-before-make dead time on coils that switch on. It

---
 rtl/coil_drive_stage.sv | 98 +++++++++
 1 files changed

// File: rtl/coil_drive_stage.sv
// coil_drive_stage: H-bridge coil driver with break-before-make dead time, PWM chopping and sticky illegal-pattern fault
module coil_drive_stage #(
    parameter int DEAD_CYCLES = 4,
    parameter int PWM_BITS    = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [3:0]          phase_in,
    input  logic                enable,
    input  logic [PWM_BITS-1:0] duty,
    input  logic                clear_fault,
    output logic [3:0]          coil_out,
    output logic                busy,
    output logic                fault
);
    localparam int CW = (DEAD_CYCLES < 2) ? 1 : $clog2(DEAD_CYCLES + 1);
    localparam logic [CW-1:0] DEAD_LOAD = CW'(DEAD_CYCLES);

    typedef enum logic [1:0] {RUN, DEAD, FAULT} state_t;

    state_t              r_state, w_state_n;
    logic [3:0]          r_phase_q, r_cur_pat, r_on_mask;
    logic [3:0]          w_cur_pat_n, w_on_mask_n, w_drive;
    logic [CW-1:0]       r_dead_cnt, w_dead_cnt_n;
    logic [PWM_BITS-1:0] r_pwm_cnt;
    logic                w_illegal, w_change, w_pwm_on;

    assign w_illegal = (r_phase_q[3] & r_phase_q[1]) | (r_phase_q[2] & r_phase_q[0]);
    assign w_change  = r_phase_q != r_cur_pat;
    assign w_pwm_on  = r_pwm_cnt < duty;
    assign busy      = r_state == DEAD;
    assign fault     = r_state == FAULT;

    // Coils only held off in DEAD are those newly energised since the last settled pattern
    always_comb begin
        w_drive = (r_state == RUN)  ? r_cur_pat :
                  (r_state == DEAD) ? (r_cur_pat & r_on_mask) : 4'b0000;
    end

    always_comb begin
        w_state_n    = r_state;
        w_cur_pat_n  = r_cur_pat;
        w_on_mask_n  = r_on_mask;
        w_dead_cnt_n = r_dead_cnt;
        case (r_state)
            RUN: begin
                if (w_illegal) begin
                    w_state_n = FAULT;
                end else if (w_change) begin
                    w_on_mask_n  = r_cur_pat & r_phase_q;
                    w_cur_pat_n  = r_phase_q;
                    w_dead_cnt_n = DEAD_LOAD;
                    w_state_n    = (DEAD_CYCLES == 0) ? RUN : DEAD;
                end
            end
            DEAD: begin
                if (w_illegal) begin
                    w_state_n = FAULT;
                end else if (w_change) begin
                    w_on_mask_n  = r_on_mask & r_phase_q;
                    w_cur_pat_n  = r_phase_q;
                    w_dead_cnt_n = DEAD_LOAD;
                end else begin
                    w_dead_cnt_n = r_dead_cnt - 1'b1;
                    w_state_n    = (r_dead_cnt == CW'(1)) ? RUN : DEAD;
                end
            end
            default: begin
                if (clear_fault && !w_illegal) begin
                    w_cur_pat_n  = r_phase_q;
                    w_on_mask_n  = 4'b0000;
                    w_dead_cnt_n = DEAD_LOAD;
                    w_state_n    = (DEAD_CYCLES == 0) ? RUN : DEAD;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_phase_q  <= 4'b0000;
            r_cur_pat  <= 4'b0000;
            r_on_mask  <= 4'b0000;
            r_dead_cnt <= '0;
            r_pwm_cnt  <= '0;
            coil_out   <= 4'b0000;
        end else begin
            r_state    <= w_state_n;
            r_phase_q  <= phase_in;
            r_cur_pat  <= w_cur_pat_n;
            r_on_mask  <= w_on_mask_n;
            r_dead_cnt <= w_dead_cnt_n;
            r_pwm_cnt  <= r_pwm_cnt + 1'b1;
            coil_out   <= w_drive & {4{w_pwm_on & enable}};
        end
    end
endmodule
